// File: rtl/fifo_pkt_if.sv
// dti valid/ready stream interface.
// consumer receives data, producer drives it.
interface dti #(
  parameter int W = 16
) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport consumer (input data, input valid, output ready);
  modport producer (output data, output valid, input ready);
endinterface

// File: rtl/fifo_pkt.sv
// fifo_pkt: circular-buffer FIFO between dti streams.
// Optional store-and-forward packet mode with oversize cut-through,
// optional output register, fill threshold and flush.
// Ports: clk, rst (async high), din (dti.consumer), dout (dti.producer),
//   flush, count (occupancy), almost_full, pkt_count (stored packets).
module fifo_pkt #(
  parameter int DEPTH     = 64,
  parameter int DIN       = 16,
  parameter int THRESHOLD = 0,
  parameter int REGOUT    = 0,
  parameter int PKT_MODE  = 0,
  parameter int EOT_BIT   = DIN - 1,
  parameter int AFULL     = DEPTH - 4
) (
  input  logic                   clk,
  input  logic                   rst,
  dti.consumer                   din,
  dti.producer                   dout,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] pkt_count
);
  localparam int CW = $clog2(DEPTH);
  localparam int NW = CW + 1;
  localparam logic [CW:0] THR = NW'(THRESHOLD);
  localparam logic [CW:0] AFL = NW'(AFULL);

  typedef enum logic {HOLD, DRAIN} state_e;

  logic [DIN-1:0] mem_q [DEPTH];
  logic [CW:0]    wptr_q, wptr_d;
  logic [CW:0]    rptr_q, rptr_d;
  logic [CW:0]    pkt_q, pkt_d;
  state_e         state_q, state_d;
  logic           ovalid_q, ovalid_d;
  logic [DIN-1:0] odata_q, odata_d;
  logic           afull_q, afull_d;
  logic [DIN-1:0] rd_word;
  logic           full, empty, avail;
  logic           push, pop, push_eot, pop_eot;

  assign rd_word = mem_q[rptr_q[CW-1:0]];
  assign empty   = wptr_q == rptr_q;
  assign full    = (wptr_q[CW] != rptr_q[CW]) &&
                   (wptr_q[CW-1:0] == rptr_q[CW-1:0]);
  assign count   = wptr_q - rptr_q;

  // In packet mode, DRAIN lets a packet larger than the
  // buffer stream through instead of deadlocking.
  always_comb begin
    avail = ~empty;
    if (PKT_MODE != 0)
      avail = ~empty & ((pkt_q != '0) | (state_q == DRAIN));
    else if (THRESHOLD > 0)
      avail = count >= THR;
  end

  assign pop = ~flush & avail &
               ((REGOUT != 0) ? (~ovalid_q | dout.ready)
                              : dout.ready);

  assign din.ready = ~flush & (~full | pop);
  assign push      = din.valid & din.ready;
  assign push_eot  = push & din.data[EOT_BIT];
  assign pop_eot   = pop & rd_word[EOT_BIT];

  assign dout.valid  = (REGOUT != 0) ? ovalid_q : avail;
  assign dout.data   = (REGOUT != 0) ? odata_q : rd_word;
  assign almost_full = afull_q;
  assign pkt_count   = pkt_q;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    pkt_d    = pkt_q;
    state_d  = state_q;
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (push_eot & ~pop_eot)
      pkt_d = pkt_q + 1'b1;
    else if (pop_eot & ~push_eot)
      pkt_d = pkt_q - 1'b1;
    unique case (state_q)
      HOLD:  if (PKT_MODE != 0 && full && pkt_q == '0)
               state_d = DRAIN;
      DRAIN: if (pop_eot) state_d = HOLD;
    endcase
    // Output stage: load on pop, clear once the word is taken.
    if (pop) begin
      ovalid_d = 1'b1;
      odata_d  = rd_word;
    end else if (dout.ready) begin
      ovalid_d = 1'b0;
    end
    if (flush) begin
      wptr_d   = '0;
      rptr_d   = '0;
      pkt_d    = '0;
      state_d  = HOLD;
      ovalid_d = 1'b0;
    end
    afull_d = (wptr_d - rptr_d) >= AFL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      pkt_q    <= '0;
      state_q  <= HOLD;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      afull_q  <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      pkt_q    <= pkt_d;
      state_q  <= state_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      afull_q  <= afull_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[CW-1:0]] <= din.data;
  end
endmodule

// File: tb/tb_fifo_pkt.sv
// Testbench for fifo_pkt: five configurations, directed stimulus,
// queue scoreboard checked by an independent output monitor.
module tb_fifo_pkt;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       in_valid;
  logic [15:0]        in_data [N];
  logic [N-1:0]       in_ready;
  logic [N-1:0][15:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;
  logic [N-1:0]       flush;
  logic [N-1:0][4:0]  cnt;
  logic [N-1:0][4:0]  pkc;
  logic [N-1:0]       afull;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q [N][$];

  // 0: D4 plain  1: D8 thr3  2: D8 pkt  3: D4 pkt  4: D8 regout
  for (genvar g = 0; g < N; g++) begin : gi
    localparam int DEP = (g == 0 || g == 3) ? 4 : 8;
    localparam int THR = (g == 1) ? 3 : 0;
    localparam int REG = (g == 4) ? 1 : 0;
    localparam int PKT = (g == 2 || g == 3) ? 1 : 0;
    localparam int CW  = $clog2(DEP);
    dti #(.W(16)) u_in ();
    dti #(.W(16)) u_out ();
    logic [CW:0] c, p;
    assign u_in.data    = in_data[g];
    assign u_in.valid   = in_valid[g];
    assign in_ready[g]  = u_in.ready;
    assign out_data[g]  = u_out.data;
    assign out_valid[g] = u_out.valid;
    assign u_out.ready  = out_ready[g];
    assign cnt[g] = 5'(c);
    assign pkc[g] = 5'(p);
    fifo_pkt #(
      .DEPTH(DEP), .DIN(16), .THRESHOLD(THR),
      .REGOUT(REG), .PKT_MODE(PKT)
    ) u_dut (
      .clk(clk), .rst(rst), .din(u_in), .dout(u_out),
      .flush(flush[g]), .count(c),
      .almost_full(afull[g]), .pkt_count(p)
    );
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (out_valid[i] && out_ready[i] && !flush[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_extra inst%0d: got %0h expected none",
                     i, out_data[i]);
          end else begin
            chk($sformatf("pop_data inst%0d", i),
                32'(out_data[i]), 32'(exp_q[i].pop_front()));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int i, logic [15:0] d);
    int t = 0;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    #1;
    while (!in_ready[i] && t < 40) begin
      tick();
      #1;
      t++;
    end
    if (t >= 40) begin
      checks++;
      failures++;
      $display("FAIL push_timeout inst%0d: got ready=0 expected ready=1", i);
    end else begin
      exp_q[i].push_back(d);
    end
    tick();
    in_valid[i] = 1'b0;
  endtask

  task automatic drain(int i);
    int t = 0;
    out_ready[i] = 1'b1;
    while (exp_q[i].size() != 0 && t < 100) begin
      tick();
      t++;
    end
    out_ready[i] = 1'b0;
    chk($sformatf("drain_left inst%0d", i), exp_q[i].size(), 0);
  endtask

  task automatic do_flush(int i);
    flush[i] = 1'b1;
    #1;
    chk("flush_ready", 32'(in_ready[i]), 0);
    tick();
    flush[i] = 1'b0;
    exp_q[i].delete();
  endtask

  initial begin
    in_valid  = '0;
    out_ready = '0;
    flush     = '0;
    for (int i = 0; i < N; i++) in_data[i] = '0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_cnt", 32'(cnt[2]), 0);
    chk("rst_pkc", 32'(pkc[2]), 0);
    chk("rst_afull", 32'(afull[2]), 0);
    chk("rst_valid", 32'(out_valid), 0);
    #9 rst = 1'b0;
    tick();

    // 1: fill DEPTH=4, then push+pop while full
    for (int k = 0; k < 4; k++) push(0, 16'(k + 1));
    chk("t1_cnt_full", 32'(cnt[0]), 4);
    chk("t1_ready_full", 32'(in_ready[0]), 0);
    chk("t1_valid", 32'(out_valid[0]), 1);
    out_ready[0] = 1'b1;
    push(0, 16'h0005);
    out_ready[0] = 1'b0;
    chk("t1_cnt_pushpop", 32'(cnt[0]), 4);
    drain(0);
    chk("t1_cnt_empty", 32'(cnt[0]), 0);
    chk("t1_valid_empty", 32'(out_valid[0]), 0);

    // 2: threshold 3
    push(1, 16'h0b00);
    push(1, 16'h0b01);
    chk("t2_valid_2w", 32'(out_valid[1]), 0);
    push(1, 16'h0b02);
    chk("t2_valid_3w", 32'(out_valid[1]), 1);
    out_ready[1] = 1'b1;
    tick();
    out_ready[1] = 1'b0;
    chk("t2_cnt_after", 32'(cnt[1]), 2);
    chk("t2_valid_below", 32'(out_valid[1]), 0);
    do_flush(1);
    chk("t2_cnt_flush", 32'(cnt[1]), 0);

    // 3: packet mode DEPTH=8
    out_ready[2] = 1'b1;
    push(2, 16'h0c00);
    chk("t3_valid_w1", 32'(out_valid[2]), 0);
    push(2, 16'h0c01);
    chk("t3_valid_w2", 32'(out_valid[2]), 0);
    push(2, 16'h8c02);
    chk("t3_valid_eot", 32'(out_valid[2]), 1);
    chk("t3_pkc_1", 32'(pkc[2]), 1);
    drain(2);
    chk("t3_pkc_0", 32'(pkc[2]), 0);
    chk("t3_cnt_0", 32'(cnt[2]), 0);

    // 4: oversize packet cut-through, DEPTH=4
    out_ready[3] = 1'b1;
    for (int k = 0; k < 4; k++) push(3, 16'(16'h0d00 + k));
    chk("t4_cnt_full", 32'(cnt[3]), 4);
    chk("t4_valid_hold", 32'(out_valid[3]), 0);
    push(3, 16'h0d04);
    push(3, 16'h8d05);
    drain(3);
    chk("t4_pkc_0", 32'(pkc[3]), 0);
    chk("t4_cnt_0", 32'(cnt[3]), 0);
    out_ready[3] = 1'b1;
    push(3, 16'h0d06);
    chk("t4_back_hold", 32'(out_valid[3]), 0);
    tick();
    chk("t4_back_hold2", 32'(out_valid[3]), 0);
    out_ready[3] = 1'b0;
    do_flush(3);

    // 5: registered output latency and stability
    push(4, 16'h1234);
    chk("t5_valid_n1", 32'(out_valid[4]), 0);
    tick();
    chk("t5_valid_n2", 32'(out_valid[4]), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_hold_valid", 32'(out_valid[4]), 1);
      chk("t5_hold_data", 32'(out_data[4]), 32'h1234);
      chk("t5_hold_cnt", 32'(cnt[4]), 0);
    end
    drain(4);
    chk("t5_valid_done", 32'(out_valid[4]), 0);

    // 6: flush with 5 words / 2 packets
    push(2, 16'h8f01);
    push(2, 16'h0f02);
    push(2, 16'h8f03);
    chk("t6_afull_3", 32'(afull[2]), 0);
    push(2, 16'h0f04);
    chk("t6_afull_4", 32'(afull[2]), 1);
    push(2, 16'h0f05);
    chk("t6_cnt_5", 32'(cnt[2]), 5);
    chk("t6_pkc_2", 32'(pkc[2]), 2);
    in_valid[2] = 1'b1;
    in_data[2]  = 16'h8f09;
    do_flush(2);
    in_valid[2] = 1'b0;
    chk("t6_cnt_flush", 32'(cnt[2]), 0);
    chk("t6_pkc_flush", 32'(pkc[2]), 0);
    chk("t6_valid_flush", 32'(out_valid[2]), 0);
    chk("t6_afull_flush", 32'(afull[2]), 0);

    // async reset mid-packet
    push(0, 16'h0a01);
    push(0, 16'h0a02);
    push(2, 16'h0011);
    chk("t6_cnt_pre_rst", 32'(cnt[0]), 2);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_cnt", 32'(cnt[0]), 0);
    chk("t6_async_valid", 32'(out_valid[0]), 0);
    chk("t6_async_cnt2", 32'(cnt[2]), 0);
    for (int i = 0; i < N; i++) exp_q[i].delete();
    #2 rst = 1'b0;
    tick();
    out_ready[2] = 1'b1;
    push(2, 16'h8012);
    drain(2);
    chk("t6_post_rst_pkc", 32'(pkc[2]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fifo_pkt.md
Name: fifo_pkt

Overview:
- Parametrised successor to the team's DTI FIFO.
- Circular-buffer FIFO between a dti consumer and a dti producer, with optional output register and fill threshold.
- Adds: packet (store-and-forward) mode keyed on an eot bit, an oversize-packet cut-through escape, exact occupancy and almost-full status outputs, and a synchronous flush.
- Used ahead of packet-oriented consumers (DMA, framers) that must not see partial packets.

Parameters:
- DEPTH, 64, number of entries; power of 2, >= 2.
- DIN, 16, data width in bits.
- THRESHOLD, 0, minimum occupancy before dout.valid may assert; 0 = disabled; ignored when PKT_MODE=1.
- REGOUT, 0, 1 = registered output stage (adds one cycle of latency).
- PKT_MODE, 0, 1 = release data only once a complete packet is stored.
- EOT_BIT, DIN-1, index of the end-of-packet flag within the data word.
- AFULL, DEPTH-4, almost_full asserts when count >= AFULL.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- din  dti.consumer  DIN  input stream (data, valid, ready)
- dout  dti.producer  DIN  output stream (data, valid, ready)
- flush  input  1  synchronous clear of all contents
- count  output  $clog2(DEPTH)+1  exact occupancy, 0..DEPTH
- almost_full  output  1  registered; count >= AFULL
- pkt_count  output  $clog2(DEPTH)+1  number of complete packets stored

Behaviour:
- Reset (async assert, sync release):
  - read/write pointers = 0, count = 0, pkt_count = 0, almost_full = 0.
  - dout.valid = 0, FSM = HOLD.
  - dout.data is don't-care.
- Pointers are CW+1 bits (CW = log2 DEPTH); the MSB is the wrap bit.
  - full = low bits equal and MSBs differ; empty = pointers equal.
  - count = wptr - rptr, taken at full CW+1 width, so count reads DEPTH when full (never truncated to 0).
- push = din.valid & din.ready. RAM write occurs at the clock edge; wptr advances by 1 and wraps naturally.
- pop = RAM read-side handshake. rptr advances by 1.
  - REGOUT=0: pop = dout.valid & dout.ready.
  - REGOUT=1: pop = avail & (!out_valid_reg | dout.ready).
- din.ready = ~flush & (~full | pop). Push and pop in the same cycle while full is legal; count stays unchanged.
- avail (RAM side has something to release):
  - PKT_MODE=0, THRESHOLD=0: ~empty.
  - PKT_MODE=0, THRESHOLD>0: count >= THRESHOLD.
  - PKT_MODE=1: ~empty & (pkt_count > 0 | state == DRAIN).
- Latency:
  - REGOUT=0: a word pushed at edge N gives dout.valid in cycle N+1 (first-word fall-through).
  - REGOUT=1: dout.valid in cycle N+2.
  - PKT_MODE adds no latency beyond the push of the eot word.
- pkt_count:
  - +1 on a push with data[EOT_BIT]=1.
  - -1 on a pop of a word with eot=1.
  - Both in the same cycle: unchanged.
- FSM (PKT_MODE=1 only):
  - HOLD -> DRAIN when full & pkt_count == 0 (packet longer than DEPTH; cut-through prevents deadlock).
  - DRAIN -> HOLD on the pop of an eot word.
  - Any flush -> HOLD.
- dout.valid, once asserted, must hold with stable data until dout.ready (DTI rule). flush is the only exception.
- flush (sync, one cycle):
  - Next edge: rptr = wptr = 0, count = 0, pkt_count = 0, dout.valid = 0, FSM = HOLD.
  - din.ready = 0 during the flush cycle; no push occurs.
  - flush overrides a simultaneous push or pop.
- almost_full is registered from next-state count; it updates on the same edge as count.
- Reset asserted mid-packet: all state is lost immediately; the partial packet is discarded.

Test Plan:
1. DEPTH=4, PKT_MODE=0: push 4 words with dout.ready=0 -> count=4, din.ready=0; drive dout.ready=1 plus a push in the same cycle -> count stays 4, data order preserved.
2. THRESHOLD=3, REGOUT=0: push 2 words -> dout.valid=0; push a 3rd -> dout.valid=1 the next cycle.
3. PKT_MODE=1, DEPTH=8: push 3 words with eot on the 3rd -> dout.valid stays 0 until the cycle after word 3; pkt_count=1, then 0 after its eot is popped.
4. PKT_MODE=1, DEPTH=4: push a 6-word packet with dout.ready=1 -> full at 4 words, FSM enters DRAIN, all 6 words emerge in order, FSM returns to HOLD.
5. REGOUT=1: single push at edge N -> dout.valid at N+2; hold dout.ready=0 for 5 cycles -> data stable, count=0, dout.valid=1.
6. Async rst and flush: assert flush with count=5 and pkt_count=2 -> both 0 next edge, dout.valid=0; pulse rst between clock edges -> outputs clear without waiting for a clock edge.
